// File: rtl/r16_pkg.sv
// Shared types and defaults for the R16 modulus / inverse delay lanes.
package r16_pkg;

    localparam int unsigned P_WIDTH_DEFAULT = 64;
    localparam int unsigned P_TAG_W_DEFAULT = 4;

    typedef logic [P_WIDTH_DEFAULT-1:0] n_t;
    typedef logic [P_WIDTH_DEFAULT:0]   ninv2_t;
    typedef logic [P_TAG_W_DEFAULT-1:0] tag_t;

    localparam n_t     N_ZERO     = '0;
    localparam ninv2_t NINV2_ZERO = '0;
    localparam tag_t   TAG_ZERO   = '0;

endpackage

// File: rtl/r16_delay_lane.sv
// One delay lane: DEPTH stages of {valid, tag, data} with stall, clear and optional sticky output.
module r16_delay_lane #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = 4,
    parameter bit          STICKY = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             clr,
    input  logic             vld_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             vld_out
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [TAG_W-1:0] tag_d  [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    // Source feeding each stage: index 0 is the lane input, index k is stage k-1.
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [TAG_W-1:0] src_tag  [DEPTH];
    logic [DEPTH-1:0] src_vld;

    // Build the per-stage source view of the shift chain.
    always_comb begin
        src_data[0] = data_in;
        src_tag[0]  = tag_in;
        src_vld[0]  = vld_in;
        for (int k = 1; k < DEPTH; k++) begin
            src_data[k] = data_q[k-1];
            src_tag[k]  = tag_q[k-1];
            src_vld[k]  = vld_q[k-1];
        end
    end

    // Next state: clear drops valids only, advance shifts, otherwise hold.
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        vld_d  = vld_q;
        if (clr) begin
            vld_d = '0;
        end else if (adv) begin
            for (int k = 0; k < DEPTH; k++) begin
                // A sticky output stage only takes valid words, so bubbles never overwrite it.
                if (!STICKY || (k != DEPTH - 1) || src_vld[k]) begin
                    data_d[k] = src_data[k];
                    tag_d[k]  = src_tag[k];
                    vld_d[k]  = src_vld[k];
                end
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
            vld_q <= '0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            vld_q  <= vld_d;
        end
    end

    assign data_out = data_q[DEPTH-1];
    assign tag_out  = tag_q[DEPTH-1];
    assign vld_out  = vld_q[DEPTH-1];

endmodule

// File: rtl/r16_mod_delay_lanes.sv
// Carries N and Ninv2 down two independently sized delay lanes with shared generation tags.
module r16_mod_delay_lanes
    import r16_pkg::*;
#(
    parameter int unsigned P_WIDTH      = P_WIDTH_DEFAULT,
    parameter int unsigned P_N_DEPTH    = 2,
    parameter int unsigned P_NINV_DEPTH = 1,
    parameter int unsigned P_TAG_W      = P_TAG_W_DEFAULT,
    parameter int unsigned P_STICKY     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               flush,
    input  logic               load_in,
    input  logic [P_WIDTH-1:0] N_in,
    input  logic [P_WIDTH:0]   Ninv2_in,
    output logic [P_WIDTH-1:0] N_Dn_out,
    output logic               N_vld_out,
    output logic [P_TAG_W-1:0] N_tag_out,
    output logic [P_WIDTH:0]   Ninv2_Dn_out,
    output logic               Ninv2_vld_out,
    output logic [P_TAG_W-1:0] Ninv2_tag_out,
    output logic               match_out
);

    if (P_N_DEPTH < 1 || P_NINV_DEPTH < 1 || P_TAG_W < 1) begin : g_bad_params
        $fatal(1, "r16_mod_delay_lanes: depths and P_TAG_W must be >= 1");
    end

    logic [P_TAG_W-1:0] tag_cnt_q;
    logic [P_TAG_W-1:0] tag_cnt_d;
    logic               adv;

    // Flush outranks enable; a load during flush or stall is dropped.
    assign adv = en & ~flush;

    // Generation counter: cleared by flush, bumped per accepted load.
    always_comb begin
        tag_cnt_d = tag_cnt_q;
        if (flush) begin
            tag_cnt_d = '0;
        end else if (en && load_in) begin
            tag_cnt_d = tag_cnt_q + 1'b1;
        end
    end

    // Tag counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_cnt_q <= '0;
        end else begin
            tag_cnt_q <= tag_cnt_d;
        end
    end

    r16_delay_lane #(
        .WIDTH  (P_WIDTH),
        .DEPTH  (P_N_DEPTH),
        .TAG_W  (P_TAG_W),
        .STICKY (P_STICKY != 0)
    ) u_n_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv),
        .clr      (flush),
        .vld_in   (load_in),
        .tag_in   (tag_cnt_q),
        .data_in  (N_in),
        .data_out (N_Dn_out),
        .tag_out  (N_tag_out),
        .vld_out  (N_vld_out)
    );

    r16_delay_lane #(
        .WIDTH  (P_WIDTH + 1),
        .DEPTH  (P_NINV_DEPTH),
        .TAG_W  (P_TAG_W),
        .STICKY (P_STICKY != 0)
    ) u_ninv2_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv),
        .clr      (flush),
        .vld_in   (load_in),
        .tag_in   (tag_cnt_q),
        .data_in  (Ninv2_in),
        .data_out (Ninv2_Dn_out),
        .tag_out  (Ninv2_tag_out),
        .vld_out  (Ninv2_vld_out)
    );

    assign match_out = N_vld_out & Ninv2_vld_out & (N_tag_out == Ninv2_tag_out);

endmodule

// File: tb/tb_r16_mod_delay_lanes.sv
// Scoreboard bench: a sticky/4-bit-tag instance and a non-sticky/2-bit-tag instance share stimulus.
module tb_r16_mod_delay_lanes;

    logic        clk = 1'b0;
    logic        rst_n, en, flush, load_in;
    logic [63:0] N_in;
    logic [64:0] Ninv2_in;

    logic [63:0] a_n, b_n;
    logic [64:0] a_ni, b_ni;
    logic        a_nv, a_niv, a_m, b_nv, b_niv, b_m;
    logic [3:0]  a_nt, a_nit;
    logic [1:0]  b_nt, b_nit;

    always #5 clk = ~clk;

    r16_mod_delay_lanes u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .flush         (flush),
        .load_in       (load_in),
        .N_in          (N_in),
        .Ninv2_in      (Ninv2_in),
        .N_Dn_out      (a_n),
        .N_vld_out     (a_nv),
        .N_tag_out     (a_nt),
        .Ninv2_Dn_out  (a_ni),
        .Ninv2_vld_out (a_niv),
        .Ninv2_tag_out (a_nit),
        .match_out     (a_m)
    );

    r16_mod_delay_lanes #(
        .P_STICKY (0),
        .P_TAG_W  (2)
    ) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .flush         (flush),
        .load_in       (load_in),
        .N_in          (N_in),
        .Ninv2_in      (Ninv2_in),
        .N_Dn_out      (b_n),
        .N_vld_out     (b_nv),
        .N_tag_out     (b_nt),
        .Ninv2_Dn_out  (b_ni),
        .Ninv2_vld_out (b_niv),
        .Ninv2_tag_out (b_nit),
        .match_out     (b_m)
    );

    // Lanes: 0 = a.N (depth 2), 1 = a.Ninv2 (depth 1), 2 = b.N (depth 2), 3 = b.Ninv2 (depth 1).
    typedef struct {
        int          lane;
        logic [64:0] data;
        logic [3:0]  tag;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          ecnt = 0;
    logic [3:0]  tm_a;
    logic [1:0]  tm_b;
    logic        ev[4];
    logic [64:0] ed[4];
    logic [3:0]  et[4];
    logic        dk[4];

    task automatic chk(input string name, input logic [64:0] obs, input logic [64:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp_v);
        end
    endtask

    task automatic push(input int lane, input logic [64:0] d, input logic [3:0] t, input int due);
        exp_t e;
        e.lane = lane;
        e.data = d;
        e.tag  = t;
        e.due  = due;
        sb.push_back(e);
    endtask

    task automatic model_edge(input logic r, input logic e, input logic f, input logic ld,
                              input logic [63:0] n, input logic [64:0] ni);
        bit found;
        if (!r) begin
            sb.delete();
            tm_a = '0;
            tm_b = '0;
            for (int i = 0; i < 4; i++) begin
                ev[i] = 1'b0; ed[i] = '0; et[i] = '0; dk[i] = 1'b1;
            end
        end else if (f) begin
            sb.delete();
            tm_a = '0;
            tm_b = '0;
            for (int i = 0; i < 4; i++) ev[i] = 1'b0;
        end else if (e) begin
            ecnt++;
            if (ld) begin
                push(0, {1'b0, n}, tm_a, ecnt + 1);
                push(1, ni, tm_a, ecnt);
                push(2, {1'b0, n}, {2'b00, tm_b}, ecnt + 1);
                push(3, ni, {2'b00, tm_b}, ecnt);
                tm_a = tm_a + 4'd1;
                tm_b = tm_b + 2'd1;
            end
            for (int i = 0; i < 4; i++) begin
                found = 1'b0;
                for (int j = 0; j < sb.size(); j++) begin
                    if (sb[j].lane == i && sb[j].due == ecnt) begin
                        ev[i] = 1'b1;
                        ed[i] = sb[j].data;
                        et[i] = sb[j].tag;
                        dk[i] = 1'b1;
                        sb.delete(j);
                        found = 1'b1;
                        break;
                    end
                end
                if (!found && i >= 2) begin
                    ev[i] = 1'b0;
                    dk[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a_n_vld", 65'(a_nv), 65'(ev[0]));
        chk("a_ni_vld", 65'(a_niv), 65'(ev[1]));
        chk("b_n_vld", 65'(b_nv), 65'(ev[2]));
        chk("b_ni_vld", 65'(b_niv), 65'(ev[3]));
        if (dk[0]) begin
            chk("a_n_data", 65'(a_n), ed[0]);
            chk("a_n_tag", 65'(a_nt), 65'(et[0]));
        end
        if (dk[1]) begin
            chk("a_ni_data", a_ni, ed[1]);
            chk("a_ni_tag", 65'(a_nit), 65'(et[1]));
        end
        if (dk[2]) begin
            chk("b_n_data", 65'(b_n), ed[2]);
            chk("b_n_tag", 65'(b_nt), 65'(et[2]));
        end
        if (dk[3]) begin
            chk("b_ni_data", b_ni, ed[3]);
            chk("b_ni_tag", 65'(b_nit), 65'(et[3]));
        end
        chk("a_match", 65'(a_m), 65'(ev[0] & ev[1] & (et[0] == et[1])));
        chk("b_match", 65'(b_m), 65'(ev[2] & ev[3] & (et[2] == et[3])));
    endtask

    task automatic cyc(input logic r, input logic e, input logic f, input logic ld,
                       input logic [63:0] n, input logic [64:0] ni);
        rst_n    = r;
        en       = e;
        flush    = f;
        load_in  = ld;
        N_in     = n;
        Ninv2_in = ni;
        @(posedge clk);
        model_edge(r, e, f, ld, n, ni);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; load_in = 1'b0;
        N_in = '0; Ninv2_in = '0;

        // Reset with random inputs, then idle with enable high.
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), {$urandom, $urandom}, {1'($urandom), $urandom, $urandom});
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);

        // Single load.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 64'h1234, 65'h1_0000_0000_0000_0ABC);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);

        // Load followed by a three-cycle stall.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 64'hBEEF_0001, 65'h1_0000_0000_0000_5555);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'hDEAD, 65'hDEAD);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);

        // Back-to-back loads.
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 64'(i), 65'(i + 100));
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);

        // Flush mid-flight, then flush concurrent with a load, then a fresh load.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 64'h55, 65'h155);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 64'h66, 65'h166);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 64'h77, 65'h177);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);

        // Tag wrap: five loads after a flush.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 64'(i + 16), 65'(i + 32));
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);

        // Reset again with a word in flight.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 64'h99, 65'h199);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
